// File: rtl/lcd_frame_receiver_pkg.sv
// rtl/lcd_frame_receiver_pkg.sv - shared opcodes, DDRAM address constants and FSM states
package lcd_frame_receiver_pkg;

   // Command opcodes; each is the lowest value whose highest set bit selects that command
   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
   localparam logic [7:0] LCD_CMD_ENTRY = 8'h04;
   localparam logic [7:0] LCD_CMD_DISP  = 8'h08;
   localparam logic [7:0] LCD_CMD_FUNC  = 8'h20;
   localparam logic [7:0] LCD_CMD_CGRAM = 8'h40;
   localparam logic [7:0] LCD_CMD_SETDD = 8'h80;

   // Two-line DDRAM layout: line 1 is 0x00..0x27, line 2 is 0x40..0x67
   localparam logic [6:0] LINE2_BASE = 7'h40;
   localparam logic [6:0] LINE_END   = 7'h27;
   localparam logic [6:0] LINE2_END  = LINE2_BASE + LINE_END;

   typedef enum logic [1:0] {
      ST_MODE8 = 2'd0,
      ST_HI    = 2'd1,
      ST_LO    = 2'd2
   } rx_state_e;

endpackage

// File: rtl/lcd_bus_sync.sv
// rtl/lcd_bus_sync.sv - LCD bus synchronizer and E pulse-width filter
module lcd_bus_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_E_HIGH  = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       e_i,
   input  logic       rs_i,
   input  logic       rw_i,
   input  logic [3:0] dat_i,
   output logic       strobe_o,
   output logic       rs_o,
   output logic       rw_o,
   output logic [3:0] dat_o,
   output logic       glitch_o
);

   localparam int CW = $clog2(MIN_E_HIGH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MIN_E_HIGH);

   logic [6:0]    sync_q [SYNC_STAGES];
   logic [6:0]    synced;
   logic          e_prev_q;
   logic [CW-1:0] cnt_q;
   logic          fall;
   logic          strobe_q, glitch_q, rs_q, rw_q;
   logic [3:0]    dat_q;

   assign synced = sync_q[SYNC_STAGES-1];
   assign fall   = e_prev_q & ~synced[6];

   // Shift {e,rs,rw,dat} through the synchronizer chain
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {e_i, rs_i, rw_i, dat_i};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Measure E high time and classify each falling edge as strobe or glitch
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         e_prev_q <= 1'b0;
         cnt_q    <= '0;
         strobe_q <= 1'b0;
         glitch_q <= 1'b0;
         rs_q     <= 1'b0;
         rw_q     <= 1'b0;
         dat_q    <= 4'h0;
      end else begin
         e_prev_q <= synced[6];
         if (!synced[6])         cnt_q <= '0;
         else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
         strobe_q <= fall && (cnt_q == CNT_MAX);
         glitch_q <= fall && (cnt_q != CNT_MAX);
         rs_q     <= synced[5];
         rw_q     <= synced[4];
         dat_q    <= synced[3:0];
      end
   end

   assign strobe_o = strobe_q;
   assign glitch_o = glitch_q;
   assign rs_o     = rs_q;
   assign rw_o     = rw_q;
   assign dat_o    = dat_q;

endmodule

// File: rtl/lcd_frame_receiver.sv
// rtl/lcd_frame_receiver.sv - decodes the 4-bit LCD bus back into a 32-character frame
module lcd_frame_receiver
   import lcd_frame_receiver_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter int         MIN_E_HIGH  = 3,
   parameter logic [7:0] FILL_CHAR   = 8'h20
) (
   input  logic         CCLK,
   input  logic         rst,
   input  logic         lcd_e,
   input  logic         lcd_rs,
   input  logic         lcd_rw,
   input  logic [3:0]   lcd_dat,
   output logic [255:0] frame,
   output logic         byte_valid,
   output logic         byte_rs,
   output logic [7:0]   byte_data,
   output logic         mode4,
   output logic         clr_pulse,
   output logic [7:0]   glitch_cnt
);

   // Next DDRAM address with the two-line wrap of the controller
   function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
      if (up) begin
         if (a == LINE_END)  return LINE2_BASE;
         if (a == LINE2_END) return 7'h00;
         return a + 7'd1;
      end
      if (a == 7'h00)      return LINE2_END;
      if (a == LINE2_BASE) return LINE_END;
      return a - 7'd1;
   endfunction

   // {visible, char index}: only the first 16 columns of each line are in the frame
   function automatic logic [5:0] char_slot(input logic [6:0] a);
      if (a[6:4] == 3'b000)           return {2'b10, a[3:0]};
      if (a[6:4] == LINE2_BASE[6:4])  return {2'b11, a[3:0]};
      return 6'b0;
   endfunction

   logic         strobe, s_rs, s_rw, glitch;
   logic [3:0]   s_dat;
   rx_state_e    state_q;
   logic [6:0]   addr_q;
   logic         inc_q, hi_rs_q, hi_rw_q;
   logic [3:0]   hi_dat_q;
   logic [255:0] frame_q;
   logic         byte_valid_q, byte_rs_q, mode4_q, clr_q;
   logic [7:0]   byte_data_q, glitch_cnt_q;
   logic         exec_en, exec_rs;
   logic [7:0]   exec_b;
   logic [5:0]   slot;

   lcd_bus_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .MIN_E_HIGH (MIN_E_HIGH)
   ) u_sync (
      .clk_i   (CCLK),
      .rst_i   (rst),
      .e_i     (lcd_e),
      .rs_i    (lcd_rs),
      .rw_i    (lcd_rw),
      .dat_i   (lcd_dat),
      .strobe_o(strobe),
      .rs_o    (s_rs),
      .rw_o    (s_rw),
      .dat_o   (s_dat),
      .glitch_o(glitch)
   );

   assign slot = char_slot(addr_q);

   // Assemble the byte a strobe would execute, and whether it executes at all
   always_comb begin
      exec_en = 1'b0;
      exec_rs = s_rs;
      exec_b  = {s_dat, 4'h0};
      if (strobe) begin
         case (state_q)
            ST_MODE8: exec_en = !s_rw && !(!s_rs && s_dat == 4'h2);
            ST_LO: begin
               exec_en = !hi_rw_q;
               exec_rs = hi_rs_q;
               exec_b  = {hi_dat_q, s_dat};
            end
            default: exec_en = 1'b0;
         endcase
      end
   end

   // Bus FSM, command/data execution and all registered outputs
   always_ff @(posedge CCLK or posedge rst) begin
      if (rst) begin
         state_q      <= ST_MODE8;
         addr_q       <= 7'h00;
         inc_q        <= 1'b1;
         hi_dat_q     <= 4'h0;
         hi_rs_q      <= 1'b0;
         hi_rw_q      <= 1'b0;
         frame_q      <= {32{FILL_CHAR}};
         byte_valid_q <= 1'b0;
         byte_rs_q    <= 1'b0;
         byte_data_q  <= 8'h00;
         mode4_q      <= 1'b0;
         clr_q        <= 1'b0;
         glitch_cnt_q <= 8'h00;
      end else begin
         byte_valid_q <= 1'b0;
         clr_q        <= 1'b0;
         if (glitch && glitch_cnt_q != 8'hFF) glitch_cnt_q <= glitch_cnt_q + 8'd1;
         if (strobe) begin
            case (state_q)
               ST_MODE8: begin
                  if (!s_rw && !s_rs && s_dat == 4'h2) begin
                     mode4_q <= 1'b1;
                     state_q <= ST_HI;
                  end
               end
               ST_HI: begin
                  hi_dat_q <= s_dat;
                  hi_rs_q  <= s_rs;
                  hi_rw_q  <= s_rw;
                  state_q  <= ST_LO;
               end
               default: state_q <= ST_HI;
            endcase
         end
         if (exec_en) begin
            byte_valid_q <= 1'b1;
            byte_rs_q    <= exec_rs;
            byte_data_q  <= exec_b;
            if (exec_rs) begin
               if (slot[5]) frame_q[{~slot[4:0], 3'b000} +: 8] <= exec_b;
               addr_q <= addr_step(addr_q, inc_q);
            end else if (exec_b >= LCD_CMD_SETDD) begin
               addr_q <= exec_b[6:0];
            end else if (exec_b >= LCD_CMD_CGRAM) begin
               clr_q <= 1'b0;
            end else if (exec_b >= LCD_CMD_FUNC) begin
               if (exec_b[4]) begin
                  state_q <= ST_MODE8;
                  mode4_q <= 1'b0;
               end
            end else if (exec_b >= LCD_CMD_DISP) begin
               clr_q <= 1'b0;
            end else if (exec_b >= LCD_CMD_ENTRY) begin
               inc_q <= exec_b[1];
            end else if (exec_b >= LCD_CMD_HOME) begin
               addr_q <= 7'h00;
            end else if (exec_b >= LCD_CMD_CLEAR) begin
               frame_q <= {32{FILL_CHAR}};
               addr_q  <= 7'h00;
               inc_q   <= 1'b1;
               clr_q   <= 1'b1;
            end
         end
      end
   end

   assign frame      = frame_q;
   assign byte_valid = byte_valid_q;
   assign byte_rs    = byte_rs_q;
   assign byte_data  = byte_data_q;
   assign mode4      = mode4_q;
   assign clr_pulse  = clr_q;
   assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_lcd_frame_receiver.sv
// tb/tb_lcd_frame_receiver.sv - self-checking bench for lcd_frame_receiver
module tb_lcd_frame_receiver;

   logic         CCLK;
   logic         rst;
   logic         lcd_e, lcd_rs, lcd_rw;
   logic [3:0]   lcd_dat;
   logic [255:0] frame;
   logic         byte_valid, byte_rs, mode4, clr_pulse;
   logic [7:0]   byte_data, glitch_cnt;

   lcd_frame_receiver dut (
      .CCLK      (CCLK),
      .rst       (rst),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_dat   (lcd_dat),
      .frame     (frame),
      .byte_valid(byte_valid),
      .byte_rs   (byte_rs),
      .byte_data (byte_data),
      .mode4     (mode4),
      .clr_pulse (clr_pulse),
      .glitch_cnt(glitch_cnt)
   );

   initial CCLK = 1'b0;
   always #5 CCLK = ~CCLK;

   int errors = 0;
   int checks = 0;

   // observed executed bytes {rs,byte} and clear-pulse cycles
   logic [8:0] obs_q[$];
   int         clr_obs = 0;

   always @(negedge CCLK) begin
      if (!rst) begin
         if (byte_valid) obs_q.push_back({byte_rs, byte_data});
         if (clr_pulse)  clr_obs++;
      end
   end

   // reference model: display memory as 80 linear cells, visible window is columns 0..15
   logic [7:0] chars_m[32];
   int         addr_m;
   logic       inc_m, mode4_m, hi_pend;
   logic [3:0] hi_dat;
   logic       hi_rs, hi_rw;
   int         glitch_m;
   int         clr_exp;
   logic [8:0] exp_q[$];

   function automatic int char_index(int a);
      if (a >= 0 && a < 16)   return a;
      if (a >= 64 && a < 80)  return a - 48;
      return -1;
   endfunction

   function automatic int next_addr(int a, logic up);
      int p;
      p = (a < 64) ? a : a - 64 + 40;
      p = up ? (p + 1) % 80 : (p + 79) % 80;
      return (p < 40) ? p : p - 40 + 64;
   endfunction

   function automatic logic [255:0] model_frame();
      logic [255:0] f;
      for (int i = 0; i < 32; i++) f[255 - 8*i -: 8] = chars_m[i];
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) chars_m[i] = 8'h20;
      addr_m = 0; inc_m = 1'b1; mode4_m = 1'b0; hi_pend = 1'b0;
      glitch_m = 0; clr_exp = 0;
      exp_q.delete();
   endtask

   task automatic model_exec(input logic rs, input logic [7:0] b);
      int msb;
      int idx;
      exp_q.push_back({rs, b});
      if (rs) begin
         idx = char_index(addr_m);
         if (idx >= 0) chars_m[idx] = b;
         addr_m = next_addr(addr_m, inc_m);
         return;
      end
      msb = -1;
      for (int k = 0; k < 8; k++) if (b[k]) msb = k;
      case (msb)
         7: addr_m = int'(b) - 128;
         5: if (b[4]) mode4_m = 1'b0;
         2: inc_m = b[1];
         1: addr_m = 0;
         0: begin
            for (int i = 0; i < 32; i++) chars_m[i] = 8'h20;
            addr_m = 0; inc_m = 1'b1; clr_exp++;
         end
         default: ;
      endcase
   endtask

   task automatic model_nib(input logic rs, input logic rw, input logic [3:0] d, input logic long_e);
      if (!long_e) begin
         if (glitch_m < 255) glitch_m++;
         return;
      end
      if (!mode4_m) begin
         if (!rw && !rs && d == 4'h2) begin
            mode4_m = 1'b1; hi_pend = 1'b0;
         end else if (!rw) begin
            model_exec(rs, {d, 4'h0});
         end
      end else if (!hi_pend) begin
         hi_pend = 1'b1; hi_dat = d; hi_rs = rs; hi_rw = rw;
      end else begin
         hi_pend = 1'b0;
         if (!hi_rw) model_exec(hi_rs, {hi_dat, d});
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CCLK);
      #1;
   endtask

   task automatic send_nib(input logic rs, input logic rw, input logic [3:0] d, input int hi_cyc);
      lcd_rs = rs; lcd_rw = rw; lcd_dat = d;
      tick(1);
      lcd_e = 1'b1;
      tick(hi_cyc);
      lcd_e = 1'b0;
      tick(7);
      model_nib(rs, rw, d, hi_cyc >= 3);
   endtask

   task automatic send_byte(input logic rs, input logic rw, input logic [7:0] b);
      send_nib(rs, rw, b[7:4], 5);
      send_nib(rs, rw, b[3:0], 5);
   endtask

   task automatic do_reset();
      lcd_e = 1'b0;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      model_reset();
      obs_q.delete();
      clr_obs = 0;
   endtask

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_bytes(input string tag);
      check({tag, "_count"}, 256'(obs_q.size()), 256'(exp_q.size()));
      while (obs_q.size() > 0 && exp_q.size() > 0)
         check(tag, 256'(obs_q.pop_front()), 256'(exp_q.pop_front()));
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_state(input string tag);
      check({tag, "_frame"}, frame, model_frame());
      check({tag, "_mode4"}, 256'(mode4), 256'(mode4_m));
      check({tag, "_glitch"}, 256'(glitch_cnt), 256'(glitch_m));
      check({tag, "_clr"}, 256'(clr_obs), 256'(clr_exp));
   endtask

   initial begin
      int r;
      logic [7:0] b;
      rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_dat = 4'h0;

      // reset values
      do_reset();
      check("rst_frame", frame, {32{8'h20}});
      check("rst_mode4", 256'(mode4), 256'(0));
      check("rst_glitch", 256'(glitch_cnt), 256'(0));
      check("rst_valid", 256'({byte_valid, clr_pulse}), 256'(0));

      // 8-bit init sequence then switch to 4-bit
      send_nib(0, 0, 4'h3, 5);
      send_nib(0, 0, 4'h3, 5);
      send_nib(0, 0, 4'h3, 5);
      send_nib(0, 0, 4'h2, 5);
      check("init_nbytes", 256'(obs_q.size()), 256'(3));
      check("init_mode4", 256'(mode4), 256'(1));
      check_bytes("init_bytes");

      // line 1 and line 2 writes
      send_byte(0, 0, 8'h80);
      send_byte(1, 0, "A");
      send_byte(1, 0, "B");
      check("ab_chars", 256'(frame[255:240]), 256'(16'h4142));
      send_byte(1, 0, "C");
      send_byte(0, 0, 8'hC0);
      send_byte(1, 0, "Z");
      check("z_char16", 256'(frame[127:120]), 256'(8'h5A));
      check_state("line_writes");
      check_bytes("line_bytes");

      // clear display
      send_byte(0, 0, 8'h01);
      check("clr_frame", frame, {32{8'h20}});
      check("clr_pulse_cycles", 256'(clr_obs), 256'(1));
      send_byte(1, 0, "Q");
      check_state("after_clr");
      check_bytes("clr_bytes");

      // address wrap, both directions
      send_byte(0, 0, 8'hA7);
      send_byte(1, 0, "x");
      send_byte(1, 0, "y");
      check("wrap_inc", 256'(frame[127:120]), 256'(8'h79));
      send_byte(0, 0, 8'h80);
      send_byte(0, 0, 8'h04);
      send_byte(1, 0, "w");
      send_byte(0, 0, 8'h06);
      send_byte(1, 0, "u");
      send_byte(1, 0, "t");
      check("wrap_dec", 256'(frame[255:248]), 256'(8'h74));
      check_state("wrap");
      check_bytes("wrap_bytes");

      // short E between HI and LO nibbles is ignored
      send_nib(1, 0, 4'h4, 5);
      send_nib(1, 0, 4'hF, 1);
      send_nib(1, 0, 4'hD, 5);
      check("glitch_cnt", 256'(glitch_cnt), 256'(1));
      check("glitch_char", 256'(frame[247:240]), 256'(8'h4D));
      check_state("glitch");
      check_bytes("glitch_bytes");

      // reset between HI and LO nibble
      send_nib(1, 0, 4'h5, 5);
      do_reset();
      check("midrst_mode4", 256'(mode4), 256'(0));
      check("midrst_frame", frame, {32{8'h20}});
      send_nib(0, 0, 4'h8, 5);
      check("midrst_nbytes", 256'(obs_q.size()), 256'(1));
      check_bytes("midrst_bytes");
      check_state("midrst");

      // randomized traffic in 4-bit mode
      send_nib(0, 0, 4'h3, 5);
      send_nib(0, 0, 4'h3, 5);
      send_nib(0, 0, 4'h3, 5);
      send_nib(0, 0, 4'h2, 5);
      send_byte(0, 0, 8'h28);
      send_byte(0, 0, 8'h06);
      send_byte(0, 0, 8'h01);
      for (int it = 0; it < 60; it++) begin
         r = $urandom_range(0, 11);
         case (r)
            0: begin
               b = 8'($urandom_range(0, 1) * 64 + $urandom_range(0, 39));
               send_byte(0, 0, 8'h80 | b);
            end
            1: send_byte(0, 0, 8'h04 | 8'($urandom_range(0, 1) * 2));
            2: send_byte(0, 0, 8'h02);
            3: send_nib(1, 0, 4'($urandom_range(0, 15)), $urandom_range(1, 2));
            4: send_byte(1, 1, 8'($urandom_range(0, 255)));
            5: send_byte(0, 0, 8'h0C);
            default: send_byte(1, 0, 8'($urandom_range(33, 126)));
         endcase
         if (it % 15 == 14) begin
            check_state("rand");
            check_bytes("rand_bytes");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
